fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 21 ++
 rtl/npc.sv | 42 ++++
 rtl/fetch_stage.sv | 73 +++++++
 tb/tb_fetch_stage.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared definitions for the instruction fetch stage.
//   - next-PC select codes driven by the ID-stage decoder (npc_op)
//   - default reset PC and bubble instruction word
//   - branch offset helper used by the next-PC calculator
package fetch_stage_pkg;

    // npc_op encodings; 4-7 are reserved and behave as sequential.
    localparam logic [2:0] NPC_OP_SEQ    = 3'd0;
    localparam logic [2:0] NPC_OP_BRANCH = 3'd1;
    localparam logic [2:0] NPC_OP_JUMP   = 3'd2;
    localparam logic [2:0] NPC_OP_JR     = 3'd3;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    // Word-aligned, sign-extended branch displacement.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/npc.sv
// npc: combinational next-PC selection for the fetch stage.
// Ports:
//   pc_f      in  32  current fetch address
//   pc_d      in  32  PC of the instruction in ID (base for branch/jump)
//   npc_op    in  3   next-PC select from ID
//   branch    in  1   branch-taken flag from ID comparator
//   imm16_d   in  16  branch offset field
//   index26_d in  26  jump index field
//   rs_d      in  32  forwarded rs value for jr/jalr
//   npc       out 32  selected next fetch address
module npc
    import fetch_stage_pkg::*;
(
    input  logic [31:0] pc_f,
    input  logic [31:0] pc_d,
    input  logic [2:0]  npc_op,
    input  logic        branch,
    input  logic [15:0] imm16_d,
    input  logic [25:0] index26_d,
    input  logic [31:0] rs_d,
    output logic [31:0] npc
);

    logic [31:0] seq_pc;

    // All sums are modulo 2^32; carry out is intentionally dropped.
    assign seq_pc = pc_f + 32'd4;

    always_comb begin
        npc = seq_pc;
        case (npc_op)
            NPC_OP_SEQ:    npc = seq_pc;
            // Branch target is relative to the delay slot (pc_d + 4).
            NPC_OP_BRANCH: npc = branch ? (pc_d + 32'd4 + branch_offset(imm16_d)) : seq_pc;
            NPC_OP_JUMP:   npc = {pc_d[31:28], index26_d, 2'b00};
            // Low bits pass through untouched; alignment is checked downstream.
            NPC_OP_JR:     npc = rs_d;
            default:       npc = seq_pc;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC selection and IF/ID pipeline register.
// Redirects resolve in ID, so the word fetched alongside them is the delay
// slot and enters IF/ID normally.
// Ports:
//   clk       in  1   system clock, rising edge
//   reset     in  1   synchronous active-high reset
//   stall     in  1   freeze PC and IF/ID
//   branch    in  1   branch-taken flag
//   npc_op    in  3   next-PC select
//   imm16_d   in  16  branch offset field
//   index26_d in  26  jump index field
//   rs_d      in  32  jr/jalr target
//   instr_f   in  32  instruction memory read data for pc_f
//   pc_f      out 32  fetch address
//   instr_d   out 32  IF/ID instruction
//   pc_d      out 32  IF/ID PC
//   pc8_d     out 32  pc_d + 8 (link address)
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch,
    input  logic [2:0]  npc_op,
    input  logic [15:0] imm16_d,
    input  logic [25:0] index26_d,
    input  logic [31:0] rs_d,
    input  logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d
);

    logic [31:0] pc_f_q;
    logic [31:0] instr_d_q;
    logic [31:0] pc_d_q;
    logic [31:0] npc_val;

    npc u_npc (
        .pc_f      (pc_f_q),
        .pc_d      (pc_d_q),
        .npc_op    (npc_op),
        .branch    (branch),
        .imm16_d   (imm16_d),
        .index26_d (index26_d),
        .rs_d      (rs_d),
        .npc       (npc_val)
    );

    // Reset wins over stall and redirect; stall holds everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_q    <= RESET_PC;
            instr_d_q <= NOP_WORD;
            pc_d_q    <= RESET_PC;
        end else if (!stall) begin
            pc_f_q    <= npc_val;
            instr_d_q <= instr_f;
            pc_d_q    <= pc_f_q;
        end
    end

    assign pc_f    = pc_f_q;
    assign instr_d = instr_d_q;
    assign pc_d    = pc_d_q;
    assign pc8_d   = pc_d_q + 32'd8;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch;
    logic [2:0]  npc_op;
    logic [15:0] imm16_d;
    logic [25:0] index26_d;
    logic [31:0] rs_d;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc8_d;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: what the architectural registers must hold.
    logic [31:0] m_pc_f, m_instr_d, m_pc_d;
    bit          model_valid = 0;

    fetch_stage dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .branch    (branch),
        .npc_op    (npc_op),
        .imm16_d   (imm16_d),
        .index26_d (index26_d),
        .rs_d      (rs_d),
        .instr_f   (instr_f),
        .pc_f      (pc_f),
        .instr_d   (instr_d),
        .pc_d      (pc_d),
        .pc8_d     (pc8_d)
    );

    // Instruction memory: word content is a simple function of its address.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    assign instr_f = imem(pc_f);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        if (model_valid) begin
            check("pc_f", pc_f, m_pc_f);
            check("instr_d", instr_d, m_instr_d);
            check("pc_d", pc_d, m_pc_d);
            check("pc8_d", pc8_d, m_pc_d + 32'd8);
        end
    end

    // Drive one cycle of inputs at negedge, advance the model, return after the edge.
    task automatic cycle(input logic rst, input logic st, input logic br, input logic [2:0] op,
                         input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] rs);
        logic [31:0] target;
        @(negedge clk);
        reset = rst; stall = st; branch = br; npc_op = op;
        imm16_d = imm; index26_d = idx; rs_d = rs;
        if (rst) begin
            m_pc_f = 32'h0000_3000; m_instr_d = 32'h0; m_pc_d = 32'h0000_3000;
            model_valid = 1;
        end else if (!st) begin
            if (op == 3'd1 && br)
                target = m_pc_d + 32'd4 + (32'(signed'(imm)) * 32'd4);
            else if (op == 3'd2)
                target = {m_pc_d[31:28], 28'(idx) * 28'd4};
            else if (op == 3'd3)
                target = rs;
            else
                target = m_pc_f + 32'd4;
            m_instr_d = imem(m_pc_f);
            m_pc_d = m_pc_f;
            m_pc_f = target;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic seq();
        cycle(0, 0, 0, 3'd0, 16'h0, 26'h0, 32'h0);
    endtask

    task automatic jr(input logic [31:0] a);
        cycle(0, 0, 0, 3'd3, 16'h0, 26'h0, a);
    endtask

    initial begin
        reset = 1; stall = 0; branch = 0; npc_op = 0; imm16_d = 0; index26_d = 0; rs_d = 0;

        // Reset and sequential fetch.
        cycle(1, 0, 0, 3'd0, 16'h0, 26'h0, 32'h0);
        cycle(1, 0, 0, 3'd0, 16'h0, 26'h0, 32'h0);
        check("rst_pc_f", pc_f, 32'h3000);
        check("rst_instr_d", instr_d, 32'h0);
        check("rst_pc_d", pc_d, 32'h3000);
        seq();
        check("seq1_pc_f", pc_f, 32'h3004);
        check("seq1_instr_d", instr_d, 32'hDEAD_3000);
        seq();
        check("seq2_instr_d", instr_d, 32'hDEAD_3004);
        seq();
        check("seq3_pc_f", pc_f, 32'h300C);

        // Jump and jump-register.
        jr(32'h3020);
        seq();
        check("j_setup_pc_d", pc_d, 32'h3020);
        cycle(0, 0, 0, 3'd2, 16'h0, 26'h0000C40, 32'h0);
        check("j_pc_f", pc_f, 32'h0000_3100);
        cycle(0, 0, 0, 3'd3, 16'h0, 26'h0, 32'h0000_4000);
        check("jr_pc_f", pc_f, 32'h0000_4000);

        // Taken branch with delay slot.
        jr(32'h3010);
        seq();
        cycle(0, 0, 1, 3'd1, 16'hFFFC, 26'h0, 32'h0);
        check("br_taken_pc_f", pc_f, 32'h3004);
        check("br_slot_instr_d", instr_d, 32'hDEAD_3014);

        // Not-taken branch.
        jr(32'h3010);
        seq();
        cycle(0, 0, 0, 3'd1, 16'hFFFC, 26'h0, 32'h0);
        check("br_nt_pc_f", pc_f, 32'h3018);

        // Stall holds a pending branch.
        jr(32'h3010);
        seq();
        cycle(0, 1, 1, 3'd1, 16'hFFFC, 26'h0, 32'h0);
        cycle(0, 1, 1, 3'd1, 16'hFFFC, 26'h0, 32'h0);
        check("stall_pc_f", pc_f, 32'h3014);
        check("stall_pc_d", pc_d, 32'h3010);
        check("stall_instr_d", instr_d, 32'hDEAD_3010);
        cycle(0, 0, 1, 3'd1, 16'hFFFC, 26'h0, 32'h0);
        check("unstall_pc_f", pc_f, 32'h3004);

        // Reset beats stall and jr.
        cycle(1, 1, 0, 3'd3, 16'h0, 26'h0, 32'h1234_5678);
        check("rst_prio_pc_f", pc_f, 32'h3000);
        check("rst_prio_instr_d", instr_d, 32'h0);

        // Wrap-around.
        jr(32'hFFFF_FFFC);
        seq();
        check("wrap_pc_f", pc_f, 32'h0);
        check("wrap_pc8_d", pc8_d, 32'h0000_0004);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0), 1'($urandom),
                  3'($urandom_range(0, 7)), 16'($urandom), 26'($urandom), $urandom);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
